uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//  Serial transmitter; the outbound counterpart to the keyboard UART receiver on uart_din.
//  It sends 8N1 frames on a single tx line: one start bit, eight data bits LSB first,
//  one stop bit, no parity. Bytes are written into an internal FIFO and drained one frame
//  at a time. It is used for debug output, such as echoing keyboard codes and CPU-written
//  bytes, from the 50 MHz system clock domain.
// PARAMETERS
//  CLK_HZ      50000000  system clock frequency in Hz
//  BAUD        115200    line rate in bit/s
//  FIFO_AW     4         FIFO address width; depth = 2**FIFO_AW (16)
//  DIV         (CLK_HZ+BAUD/2)/BAUD  clocks per bit (434 at the defaults); must be >= 2
// PORTS
//  clk         in   1         system clock (50 MHz); every flop is on its rising edge
//  reset       in   1         synchronous, active-high reset
//  din         in   8         byte to enqueue
//  wr          in   1         enqueue strobe; din is sampled on each clk edge where wr=1
//  ovf_clr     in   1         clears the sticky overflow flag
//  tx          out  1         serial output; idles high
//  busy        out  1         1 while a frame is on the line (start bit through stop bit)
//  full        out  1         FIFO holds 2**FIFO_AW entries
//  empty       out  1         FIFO holds 0 entries
//  count       out  FIFO_AW+1 number of FIFO entries
//  overflow    out  1         sticky flag: a write was dropped because the FIFO was full
// BEHAVIOUR
//  Reset values
//   - tx=1, busy=0, full=0, empty=1, count=0, overflow=0.
//   - FSM returns to IDLE; FIFO pointers return to 0.
//  Reset mid-frame
//   - The frame is aborted and tx is 1 on the clock after reset is sampled.
//   - Queued bytes are discarded.
//  All outputs are registered; tx drives straight from a flop.
//  FIFO
//   - Write: when wr=1 and full=0, din is stored and count increments.
//   - Write while full=1: the byte is dropped, overflow is set, and count is unchanged.
//   - full is the registered flag. A write in the same cycle as a pop from a full FIFO
//     is still dropped.
//   - Simultaneous write (not full) and pop: count is unchanged and both operations occur.
//   - Pointers wrap modulo 2**FIFO_AW.
//   - ovf_clr=1 clears overflow. If wr-while-full occurs in the same cycle, set wins.
//  FSM states: IDLE, START, DATA, STOP. A bit counter spans 0..7 and a baud counter
//  spans 0..DIV-1.
//   - IDLE: tx=1, busy=0. If empty=0, pop the head into the shift register, move to
//     START, and clear the baud counter.
//   - START: tx=0 for exactly DIV clocks, then DATA with bit counter 0.
//   - DATA: tx=shift[0] for DIV clocks per bit, then shift right. After bit 7, go to STOP.
//   - STOP: tx=1 for DIV clocks. If empty=0 at the end, pop and go directly to START,
//     giving back-to-back frames with no idle gap. Otherwise go to IDLE.
//   - busy=1 in START, DATA and STOP.
//  Latency and timing
//   - wr sampled at edge k into an empty, idle block: the pop happens at edge k+1 and
//     tx falls after edge k+2.
//   - Frame length is exactly 10*DIV clocks.
//   - Bit boundaries never drift: the baud counter restarts only on state and bit changes.
//  din and wr are fully decoupled from the line. Writes are accepted in any state.
// TESTING
//  1. Defaults, wr with din=0x55 from reset. tx falls 2 clocks later, then shows
//     0,1,0,1,0,1,0,1,0,1 (start, LSB-first data, stop), each bit held 434 clocks.
//     busy is high for 4340 clocks and tx idles high afterwards.
//  2. Write 0x41, 0x42, 0x43 on consecutive cycles. count peaks at 2, since the first
//     byte pops immediately. Three frames go out with no idle gap and empty=1 at the end.
//  3. While a frame is in flight, write 17 bytes. The first 16 are accepted and full=1.
//     The 17th is dropped and overflow=1. ovf_clr clears overflow; all 16 bytes are sent
//     in order.
//  4. Full FIFO, wr=1 in the same cycle as the STOP->START pop. The write is dropped,
//     overflow=1, and count goes to 15.
//  5. Assert reset during DATA bit 3 with 5 bytes queued. tx=1 on the next clock,
//     count=0, busy=0, and no further frames are sent.
//  6. Use the receiver's 8-bit decoder as a monitor and loop back 0x00, 0xFF, 0xA5 and
//     0x3C. Every byte decodes correctly and the stop bit is sampled high.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//
// Serial transmitter for debug output: 8N1 frames (start bit, eight data bits
// LSB first, stop bit, no parity) on a single tx line. Bytes are queued in an
// internal FIFO and sent one frame at a time. When bytes are waiting, frames go
// out back to back with no idle gap.
//
// Parameters
//   CLK_HZ   system clock frequency in Hz
//   BAUD     line rate in bit/s
//   FIFO_AW  FIFO address width; depth = 2**FIFO_AW
//
// Ports
//   clk       in   system clock; every flop is on its rising edge
//   reset     in   synchronous, active-high reset
//   din       in   byte to enqueue
//   wr        in   enqueue strobe; din is sampled on every edge with wr=1
//   ovf_clr   in   clears the sticky overflow flag
//   tx        out  serial line, idles high
//   busy      out  high while a frame is on the line (start through stop bit)
//   full      out  FIFO holds 2**FIFO_AW entries
//   empty     out  FIFO holds no entries
//   count     out  number of FIFO entries
//   overflow  out  sticky: a write was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int CLK_HZ  = 50000000,
    parameter int BAUD    = 115200,
    parameter int FIFO_AW = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         din,
    input  logic               wr,
    input  logic               ovf_clr,
    output logic               tx,
    output logic               busy,
    output logic               full,
    output logic               empty,
    output logic [FIFO_AW:0]   count,
    output logic               overflow
);

    // Clocks per bit, rounded to nearest. Must come out >= 2.
    localparam int DIV   = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int BW    = $clog2(DIV);

    localparam logic [BW-1:0]    BAUD_LAST = BW'(DIV - 1);
    localparam logic [FIFO_AW:0] CNT_FULL  = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // ------------------------------------------------------------------
    // FIFO storage and bookkeeping
    // ------------------------------------------------------------------
    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               full_q, full_d;
    logic               empty_q, empty_d;
    logic               ovf_q, ovf_d;
    logic               push;
    logic               pop;
    logic [7:0]         head;

    // ------------------------------------------------------------------
    // Transmit FSM state
    // ------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [BW-1:0]      baud_q, baud_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shift_q, shift_d;
    logic               tx_q, tx_d;
    logic               busy_q, busy_d;
    logic               baud_last;

    // The registered full flag gates writes, so a write landing in the same
    // cycle as a pop from a full FIFO is still dropped.
    assign push = wr && !full_q;
    assign head = mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= din;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CNT_FULL);
        empty_d = (count_d == '0);

        // Setting wins over clearing when both happen in one cycle.
        ovf_d = ovf_q;
        if (wr && full_q) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state. The baud counter only restarts on state or bit
    // changes, so bit boundaries stay exactly DIV clocks apart.
    // ------------------------------------------------------------------
    assign baud_last = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!empty_q) begin
                    pop     = 1'b1;
                    shift_d = head;
                    baud_d  = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_DATA: begin
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (!empty_q) begin
                        // Chain straight into the next frame.
                        pop     = 1'b1;
                        shift_d = head;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                baud_d  = '0;
            end
        endcase

        // Line outputs are decoded from the current state and registered, so
        // tx and busy trail the state register by one clock, uniformly for
        // every bit. That keeps each bit exactly DIV clocks wide on the pin.
        case (state_q)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_q[0];
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_q != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= 3'd0;
            shift_q  <= 8'd0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
        end
    end

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign full     = full_q;
    assign empty    = empty_q;
    assign count    = count_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
//
// Directed stimulus drives bytes into uart_tx_fifo and pushes each byte that
// must reach the line into a queue. An independent monitor decodes the serial
// line like a UART receiver (mid-bit sampling) and pops/compares every frame.
// The DUT runs at 1 MHz / 100 kbaud, giving 10 clocks per bit, so the frame
// sequences fit in a short run.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

    localparam int DIV = 10;   // (1000000 + 50000) / 100000
    localparam int AW  = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    din = 8'd0;
    logic          wr = 1'b0;
    logic          ovf_clr = 1'b0;
    logic          tx;
    logic          busy;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          overflow;

    int            pass_cnt = 0;
    int            total_cnt = 0;
    int            cyc = 0;
    logic [7:0]    exp_q [$];

    // Monitor state
    bit            m_active = 1'b0;
    int            m_cnt = 0;
    logic [7:0]    m_byte = 8'd0;
    int            mon_starts = 0;

    uart_tx_fifo #(
        .CLK_HZ  (1000000),
        .BAUD    (100000),
        .FIFO_AW (AW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .din      (din),
        .wr       (wr),
        .ovf_clr  (ovf_clr),
        .tx       (tx),
        .busy     (busy),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One write strobe; accept=1 means the byte must later appear on the line.
    task automatic do_write(input logic [7:0] b, input bit accept);
        din = b;
        wr  = 1'b1;
        if (accept) exp_q.push_back(b);
        tick();
        wr = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int  n;
        bit  done;
        done = 1'b0;
        for (n = 0; n < budget; n++) begin
            if (exp_q.size() == 0 && !busy && !m_active && empty) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        check("drain_done", int'(done), 1);
        repeat (3) tick();
    endtask

    // ------------------------------------------------------------------
    // Line monitor: samples at the falling edge, mid-bit.
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (reset) begin
            m_active = 1'b0;
        end else if (!m_active) begin
            if (tx == 1'b0) begin
                m_active = 1'b1;
                m_cnt    = 0;
                m_byte   = 8'd0;
                mon_starts++;
            end
        end else begin
            m_cnt++;
            if (m_cnt == DIV / 2) begin
                check("mon_start_bit", int'(tx), 0);
            end else if (m_cnt > DIV / 2 && ((m_cnt - DIV / 2) % DIV) == 0) begin
                int idx;
                idx = (m_cnt - DIV / 2) / DIV - 1;
                if (idx < 8) begin
                    m_byte[idx] = tx;
                end else begin
                    check("mon_stop_bit", int'(tx), 1);
                    if (exp_q.size() == 0) begin
                        check("mon_unexpected_frame", int'(m_byte), -1);
                    end else begin
                        logic [7:0] e;
                        e = exp_q.pop_front();
                        $display("rx frame: byte %02h (expected %02h)", m_byte, e);
                        check("mon_byte", int'(m_byte), int'(e));
                    end
                    m_active = 1'b0;
                end
            end
        end
    end

    initial begin
        int n;
        int t0;
        int starts0;
        bit seen;

        repeat (3) tick();
        reset = 1'b0;

        // Reset state
        check("rst_tx", int'(tx), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_full", int'(full), 0);
        check("rst_empty", int'(empty), 1);
        check("rst_count", int'(count), 0);
        check("rst_overflow", int'(overflow), 0);
        tick();

        // 1. Single byte 0x55: tx falls two clocks after the write edge,
        //    busy lasts exactly 10*DIV clocks.
        do_write(8'h55, 1'b1);
        check("t1_count_after_wr", int'(count), 1);
        check("t1_tx_k", int'(tx), 1);
        tick();
        check("t1_count_after_pop", int'(count), 0);
        check("t1_tx_k1", int'(tx), 1);
        check("t1_busy_k1", int'(busy), 0);
        tick();
        check("t1_tx_k2", int'(tx), 0);
        check("t1_busy_k2", int'(busy), 1);
        n = 0;
        while (busy && n < 20 * DIV) begin
            tick();
            n++;
        end
        check("t1_busy_len", n, 10 * DIV);
        check("t1_tx_idle", int'(tx), 1);
        wait_drain(40 * DIV);

        // 2. Three consecutive writes; first pops at once so count peaks at 2.
        do_write(8'h41, 1'b1);
        check("t2_count0", int'(count), 1);
        do_write(8'h42, 1'b1);
        check("t2_count1", int'(count), 1);
        do_write(8'h43, 1'b1);
        check("t2_count2", int'(count), 2);
        check("t2_busy", int'(busy), 1);
        n = 0;
        while (busy && n < 40 * DIV) begin
            tick();
            n++;
        end
        check("t2_b2b_len", n, 30 * DIV);
        check("t2_empty", int'(empty), 1);
        wait_drain(40 * DIV);

        // 3. Fill while a frame is in flight; 17th write dropped.
        do_write(8'h10, 1'b1);
        t0 = cyc;
        tick();
        tick();
        for (int i = 0; i < 16; i++) begin
            do_write(8'h20 + 8'(i), 1'b1);
        end
        check("t3_count16", int'(count), 16);
        check("t3_full", int'(full), 1);
        check("t3_ovf_before", int'(overflow), 0);
        ovf_clr = 1'b1;                  // clear and drop in one cycle: set wins
        do_write(8'h99, 1'b0);
        ovf_clr = 1'b0;
        check("t3_ovf_set_wins", int'(overflow), 1);
        check("t3_count_kept", int'(count), 16);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("t3_ovf_cleared", int'(overflow), 0);

        // 4. Write in the same edge as the STOP->START pop of a full FIFO.
        while (cyc < t0 + 10 * DIV) tick();
        check("t4_full_before", int'(full), 1);
        check("t4_count_before", int'(count), 16);
        do_write(8'h77, 1'b0);
        check("t4_overflow", int'(overflow), 1);
        check("t4_count15", int'(count), 15);
        check("t4_not_full", int'(full), 0);
        wait_drain(400 * DIV);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;

        // 5. Reset in DATA bit 3 with 5 bytes queued: frame aborted, queue lost.
        do_write(8'hC3, 1'b0);
        t0 = cyc;
        for (int i = 0; i < 5; i++) begin
            do_write(8'h60 + 8'(i), 1'b0);
        end
        check("t5_count5", int'(count), 5);
        while (cyc < t0 + 1 + 4 * DIV + DIV / 2) tick();
        check("t5_busy_pre", int'(busy), 1);
        reset = 1'b1;
        tick();
        check("t5_tx", int'(tx), 1);
        check("t5_count", int'(count), 0);
        check("t5_busy", int'(busy), 0);
        check("t5_empty", int'(empty), 1);
        reset = 1'b0;
        starts0 = mon_starts;
        seen = 1'b0;
        repeat (30 * DIV) begin
            tick();
            if (busy || !tx) seen = 1'b1;
        end
        check("t5_no_frames", int'(seen), 0);
        check("t5_mon_starts", mon_starts, starts0);

        // 6. Loopback patterns decoded by the monitor.
        do_write(8'h00, 1'b1);
        do_write(8'hFF, 1'b1);
        do_write(8'hA5, 1'b1);
        do_write(8'h3C, 1'b1);
        wait_drain(80 * DIV);
        check("t6_overflow", int'(overflow), 0);
        check("t6_tx_idle", int'(tx), 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
